// File: rtl/prog_delay_timer_if.sv
// Control/status bundle for the programmable delay timer.
interface prog_delay_timer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             periodic;
  logic [WIDTH-1:0] delay;
  logic             busy;
  logic             done;
  logic             out;
  logic [WIDTH-1:0] count;

  // Requester side: issues commands, observes timer status.
  modport master (
    output start, stop, periodic, delay,
    input  busy, done, out, count
  );

  // Timer side.
  modport slave (
    input  start, stop, periodic, delay,
    output busy, done, out, count
  );
endinterface

// File: rtl/prog_delay_timer.sv
// Programmable delay timer: start loads delay N and mode, done pulses N
// cycles later; one-shot holds in EXPIRED, periodic reloads and toggles out.
module prog_delay_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  prog_delay_timer_if.slave  bus
);

  localparam int unsigned CW = WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] nl_q, nl_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_q, out_d;
  logic          done_q, done_d;

  logic [CW-1:0] last_c;
  logic          expire_c;

  // Terminal count of the current period and expiry detect.
  assign last_c   = CW'(nl_q - CW'(1));
  assign expire_c = (state_q == RUN) && (count_q == last_c);

  // State and datapath registers; reset parks the timer in IDLE with N=1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      nl_q    <= CW'(1);
      mode_q  <= 1'b0;
      count_q <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nl_q    <= nl_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // Next state: stop beats start beats expiry beats increment.
  always_comb begin
    state_d = state_q;
    nl_d    = nl_q;
    mode_d  = mode_q;
    count_d = count_q;
    out_d   = out_q;
    done_d  = 1'b0;

    if (bus.stop) begin
      state_d = IDLE;
      count_d = '0;
      out_d   = 1'b0;
    end else if (bus.start) begin
      // A zero delay is promoted to one so the terminal count stays valid.
      nl_d    = (bus.delay == '0) ? CW'(1) : bus.delay;
      mode_d  = bus.periodic;
      count_d = '0;
      out_d   = 1'b0;
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (expire_c) begin
            done_d = 1'b1;
            if (mode_q) begin
              count_d = '0;
              out_d   = ~out_q;
            end else begin
              state_d = EXPIRED;
              out_d   = 1'b1;
            end
          end else begin
            count_d = CW'(count_q + CW'(1));
          end
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Status outputs; busy is a direct decode of the state register.
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign bus.out   = out_q;
  assign bus.count = count_q;

endmodule

// File: doc/prog_delay_timer.md
# prog_delay_timer

Parametrised programmable delay timer: a start pulse loads a delay value N and a mode, counts clock cycles, and signals expiry exactly N cycles later. It supports one-shot and periodic (square-wave) modes, plus abort and restart. It is the generalised successor of the fixed-delay action counter. It sits between control logic and any block that needs a timed action or a slow periodic strobe.

## Interface
- WIDTH, 4, width of the delay value and the cycle counter (N range 1..2^WIDTH-1)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  synchronous request; loads delay and mode, (re)starts counting
- stop  in  1  synchronous abort; returns block to idle
- periodic  in  1  mode, sampled only on start: 0 = one-shot, 1 = periodic
- delay  in  WIDTH  delay N in cycles, sampled only on start; 0 treated as 1
- busy  out  1  high while counting (RUN state)
- done  out  1  one-cycle pulse at each expiry
- out  out  1  one-shot: high from expiry until next start/stop; periodic: toggles at each expiry
- count  out  WIDTH  current cycle count within the period

## Operation
- States: IDLE, RUN, EXPIRED.
- Registers: latched delay N_l (WIDTH bits), latched mode, count, out, done, and state. All outputs are registered.
- Reset (rst=0, asynchronous): state=IDLE, count=0, busy=0, done=0, out=0, N_l=1, mode=0.
- Priority at each edge: stop > start > expiry > count increment.
- stop=1 (any state): go to IDLE, count=0, out=0, done=0.
- start=1, stop=0 (any state, including RUN):
  - N_l = (delay==0 ? 1 : delay), mode = periodic.
  - count=0, out=0, done=0, state=RUN.
  - A coinciding expiry is discarded; no done pulse.
- RUN, count != N_l-1: count = count+1, done=0.
- RUN, count == N_l-1 (expiry): done=1 for one cycle.
  - one-shot: state=EXPIRED, out=1, count holds at N_l-1.
  - periodic: stay in RUN, count=0, out toggles.
- EXPIRED: count, out and state hold; done=0. Leaves only on start or stop.
- IDLE: all outputs hold at their cleared values.
- busy is a pure decode of state==RUN (registered state, no extra latency).
- count never exceeds N_l-1. There is no wrap-around through 2^WIDTH, because N_l ≤ 2^WIDTH-1.

## Timing
- Edge E0 samples start. After E0: busy=1, count=0.
- After edge Ek (k < N): count=k.
- done is high in the cycle after edge E_N, i.e. N cycles after the start-sampling edge, for exactly one cycle.
- One-shot: out rises together with done and stays high.
- Periodic: done pulses after E_N, E_2N, E_3N, …; out toggles on the same edges, giving a square wave of period 2N.
- delay=0 behaves identically to delay=1: done after E1, and in periodic mode done is high every cycle.
- Restart in RUN: timing restarts from the new E0; the old period is abandoned.
- stop: all outputs are cleared after the edge that samples it.
- Reset mid-operation: outputs clear immediately on rst falling, without waiting for clk. On rst release, the block sits in IDLE until a start.

## Test plan
- Reset: assert rst=0 mid-count (N=9, count=5) -> busy, done, out and count are 0 immediately; no done follows after rst=1.
- One-shot, WIDTH=4, delay=5, periodic=0:
  - count steps 0..4;
  - done is high for one cycle 5 cycles after start;
  - out=1 and busy=0 thereafter;
  - count holds 4 for 20 idle cycles.
- Periodic, delay=3, periodic=1, run 20 cycles -> done pulses every 3 cycles (6 pulses); out toggles each pulse (period 6); busy stays 1.
- Edge values:
  - delay=0 periodic -> done high every cycle;
  - delay=15 one-shot -> done exactly 15 cycles after start, count max 14.
- Restart/abort:
  - delay=4, re-assert start with delay=6 on the would-be expiry cycle -> no done at cycle 4; done at 6 cycles after the second start.
  - start and stop together -> IDLE with all outputs 0.
- Stop in EXPIRED -> out falls to 0 after one edge; a subsequent start with delay=2 gives done 2 cycles later.
